alu_share_arbiter: RTL and testbench

//  Shares one ALU32 instance between two requesters (e.g. fetch-PC adder and execute stage).

---
 rtl/alu_share_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU32 between two requesters.
// Operands are registered ahead of the ALU; result and flags are registered behind it.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp0_overflow,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  output logic              rsp1_overflow,

  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,

  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;

  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;

  logic              rsp0_valid_q, rsp0_valid_d;
  logic [DATA_W-1:0] rsp0_result_q, rsp0_result_d;
  logic              rsp0_zero_q, rsp0_zero_d;
  logic              rsp0_overflow_q, rsp0_overflow_d;

  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp1_result_q, rsp1_result_d;
  logic              rsp1_zero_q, rsp1_zero_d;
  logic              rsp1_overflow_q, rsp1_overflow_d;

  logic              grant_any;
  logic              grant_sel;
  logic              in_idle;
  logic              accept;
  logic              rsp_done;

  // When both requesters compete, the one that did not win last time gets the grant.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_sel = ~last_grant_q;
    end else begin
      grant_sel = req1_valid;
    end
  end

  assign in_idle    = (state_q == IDLE);
  assign req0_ready = rst_n & in_idle & grant_any & ~grant_sel;
  assign req1_ready = rst_n & in_idle & grant_any & grant_sel;
  assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  always_comb begin
    if (grant_id_q) begin
      rsp_done = rsp1_valid_q & rsp1_ready;
    end else begin
      rsp_done = rsp0_valid_q & rsp0_ready;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    grant_id_d      = grant_id_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    alu_ctrl_d      = alu_ctrl_q;
    rsp0_valid_d    = rsp0_valid_q;
    rsp0_result_d   = rsp0_result_q;
    rsp0_zero_d     = rsp0_zero_q;
    rsp0_overflow_d = rsp0_overflow_q;
    rsp1_valid_d    = rsp1_valid_q;
    rsp1_result_d   = rsp1_result_q;
    rsp1_zero_d     = rsp1_zero_q;
    rsp1_overflow_d = rsp1_overflow_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_id_d = grant_sel;
          if (grant_sel) begin
            alu_a_d    = req1_a;
            alu_b_d    = req1_b;
            alu_ctrl_d = req1_ctrl;
          end else begin
            alu_a_d    = req0_a;
            alu_b_d    = req0_b;
            alu_ctrl_d = req0_ctrl;
          end
          state_d = EXEC;
        end
      end

      EXEC: begin
        // Only the granted requester's response registers are written.
        if (grant_id_q) begin
          rsp1_valid_d    = 1'b1;
          rsp1_result_d   = alu_result;
          rsp1_zero_d     = alu_zero;
          rsp1_overflow_d = alu_overflow;
        end else begin
          rsp0_valid_d    = 1'b1;
          rsp0_result_d   = alu_result;
          rsp0_zero_d     = alu_zero;
          rsp0_overflow_d = alu_overflow;
        end
        state_d = RESP;
      end

      RESP: begin
        if (rsp_done) begin
          if (grant_id_q) begin
            rsp1_valid_d = 1'b0;
          end else begin
            rsp0_valid_d = 1'b0;
          end
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      grant_id_q      <= 1'b0;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      alu_ctrl_q      <= '0;
      rsp0_valid_q    <= 1'b0;
      rsp0_result_q   <= '0;
      rsp0_zero_q     <= 1'b0;
      rsp0_overflow_q <= 1'b0;
      rsp1_valid_q    <= 1'b0;
      rsp1_result_q   <= '0;
      rsp1_zero_q     <= 1'b0;
      rsp1_overflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      grant_id_q      <= grant_id_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      alu_ctrl_q      <= alu_ctrl_d;
      rsp0_valid_q    <= rsp0_valid_d;
      rsp0_result_q   <= rsp0_result_d;
      rsp0_zero_q     <= rsp0_zero_d;
      rsp0_overflow_q <= rsp0_overflow_d;
      rsp1_valid_q    <= rsp1_valid_d;
      rsp1_result_q   <= rsp1_result_d;
      rsp1_zero_q     <= rsp1_zero_d;
      rsp1_overflow_q <= rsp1_overflow_d;
    end
  end

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_ctrl      = alu_ctrl_q;
  assign rsp0_valid    = rsp0_valid_q;
  assign rsp0_result   = rsp0_result_q;
  assign rsp0_zero     = rsp0_zero_q;
  assign rsp0_overflow = rsp0_overflow_q;
  assign rsp1_valid    = rsp1_valid_q;
  assign rsp1_result   = rsp1_result_q;
  assign rsp1_zero     = rsp1_zero_q;
  assign rsp1_overflow = rsp1_overflow_q;
  assign busy          = ~in_idle;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU32 hooked to the ALU ports.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp0_overflow, rsp1_zero, rsp1_overflow;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero, alu_overflow;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .CTRL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_overflow(rsp0_overflow),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_overflow(rsp1_overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .busy(busy)
  );

  // Behavioural ALU32
  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      3'b000: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b001: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      3'b010: alu_result = alu_a & alu_b;
      3'b011: alu_result = alu_a | alu_b;
      3'b101: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Present one request and return just after its accept edge (DUT then in EXEC).
  task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] ctrl);
    bit got = 1'b0;
    if (id) begin
      req1_a = a; req1_b = b; req1_ctrl = ctrl; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_ctrl = ctrl; req0_valid = 1'b1;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL accept_timeout: req%0d ready stayed 0, wanted 1", id);
    end
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  // Wait for the response of requester id; caller chooses rsp ready.
  task automatic wait_rsp(input bit id, output logic [31:0] res, output logic z,
                          output logic o);
    bit got = 1'b0;
    res = '0; z = 1'b0; o = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = id ? rsp1_valid : rsp0_valid;
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL rsp_timeout: rsp%0d_valid stayed 0, wanted 1", id);
    end
    res = id ? rsp1_result : rsp0_result;
    z   = id ? rsp1_zero : rsp0_zero;
    o   = id ? rsp1_overflow : rsp0_overflow;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #3;
    total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready); end
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 3'd0) begin bad++;
      $display("FAIL reset_alu: got %h %h %h want 0 0 0", alu_a, alu_b, alu_ctrl); end
    total++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++;
      $display("FAIL reset_rsp_valid: got %b%b want 00", rsp0_valid, rsp1_valid); end
    total++; if ({rsp0_result, rsp0_zero, rsp0_overflow, rsp1_result, rsp1_zero,
                  rsp1_overflow} !== 68'd0) begin bad++;
      $display("FAIL reset_rsp_payload: got %h %h want 0 0", rsp0_result, rsp1_result); end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    rsp0_ready = 1'b1;
    req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = 3'b000; req0_valid = 1'b1;
    @(negedge clk);
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL add_ready: got %b%b want 10", req0_ready, req1_ready); end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin bad++;
      $display("FAIL add_exec: busy=%b rsp0_valid=%b want 1 0", busy, rsp0_valid); end
    total++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_ctrl !== 3'b000) begin bad++;
      $display("FAIL add_operands: got %h %h %h want 5 7 0", alu_a, alu_b, alu_ctrl); end
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b1) begin bad++;
      $display("FAIL add_latency: rsp0_valid=%b want 1", rsp0_valid); end
    total++; if (rsp0_result !== 32'd12 || rsp0_zero !== 1'b0 || rsp0_overflow !== 1'b0)
      begin bad++;
      $display("FAIL add_result: got %h z%b o%b want 0000000c z0 o0", rsp0_result, rsp0_zero,
               rsp0_overflow); end
    @(negedge clk);
    total++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL add_done: rsp0_valid=%b busy=%b want 0 0", rsp0_valid, busy); end
    total++; if (rsp0_result !== 32'd12 || alu_a !== 32'd5) begin bad++;
      $display("FAIL add_hold: result=%h alu_a=%h want c 5", rsp0_result, alu_a); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    bit grants [4];
    int n = 0;
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_a = 32'd3; req0_b = 32'd3; req0_ctrl = 3'b001;
    req1_a = 32'hFFFF_FFFF; req1_b = 32'd1; req1_ctrl = 3'b101;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) begin
        total++; bad++;
        $display("FAIL rr_both_ready: got 11 want one-hot");
      end else if (req0_ready) begin
        grants[n] = 1'b0; n++;
      end else if (req1_ready) begin
        grants[n] = 1'b1; n++;
      end
      if (rsp0_valid) begin
        total++; if (rsp0_result !== 32'd0 || rsp0_zero !== 1'b1) begin bad++;
          $display("FAIL rr_rsp0: got %h z%b want 0 z1", rsp0_result, rsp0_zero); end
      end
      if (rsp1_valid) begin
        total++; if (rsp1_result !== 32'd1 || rsp1_zero !== 1'b0) begin bad++;
          $display("FAIL rr_rsp1: got %h z%b want 1 z0", rsp1_result, rsp1_zero); end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (n != 4) begin bad++;
      $display("FAIL rr_count: got %0d grants want 4", n); end
    total++; if ({grants[0], grants[1], grants[2], grants[3]} !== 4'b0101) begin bad++;
      $display("FAIL rr_order: got %b%b%b%b want 0101", grants[0], grants[1], grants[2],
               grants[3]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow();
    logic [31:0] r; logic z, o;
    rsp1_ready = 1'b1;
    issue(1'b1, 32'h7FFF_FFFF, 32'd1, 3'b000);
    wait_rsp(1'b1, r, z, o);
    total++; if (r !== 32'h8000_0000 || o !== 1'b1 || z !== 1'b0) begin bad++;
      $display("FAIL ovf_add: got %h z%b o%b want 80000000 z0 o1", r, z, o); end
  endtask

  task automatic test_logic();
    logic [31:0] r; logic z, o;
    rsp0_ready = 1'b1;
    issue(1'b0, 32'hF0F0_0000, 32'hFF00_FF00, 3'b010);
    wait_rsp(1'b0, r, z, o);
    total++; if (r !== 32'hF000_0000 || z !== 1'b0) begin bad++;
      $display("FAIL logic_and: got %h z%b want f0000000 z0", r, z); end
    issue(1'b0, 32'h0000_000F, 32'h0000_00F0, 3'b011);
    wait_rsp(1'b0, r, z, o);
    total++; if (r !== 32'h0000_00FF) begin bad++;
      $display("FAIL logic_or: got %h want 000000ff", r); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic z, o;
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    issue(1'b1, 32'd1, 32'd2, 3'b000);
    @(posedge clk);
    #1;
    req0_a = 32'd10; req0_b = 32'd20; req0_ctrl = 3'b000; req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (rsp1_valid !== 1'b1 || rsp1_result !== 32'd3 || req0_ready !== 1'b0 ||
                   busy !== 1'b1) begin bad++;
        $display("FAIL bp_hold[%0d]: v%b res=%h r0rdy=%b busy=%b want v1 3 0 1", i,
                 rsp1_valid, rsp1_result, req0_ready, busy); end
    end
    @(posedge clk);
    #1;
    rsp1_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp1_ready = 1'b0;
    @(negedge clk);
    total++; if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin bad++;
      $display("FAIL bp_release: rsp1_valid=%b req0_ready=%b want 0 1", rsp1_valid,
               req0_ready); end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1 || alu_a !== 32'd10) begin bad++;
      $display("FAIL bp_accept: busy=%b alu_a=%h want 1 a", busy, alu_a); end
    wait_rsp(1'b0, r, z, o);
    total++; if (r !== 32'd30) begin bad++;
      $display("FAIL bp_result: got %h want 1e", r); end
  endtask

  task automatic test_reset_mid();
    rsp0_ready = 1'b0;
    issue(1'b0, 32'd9, 32'd9, 3'b000);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin bad++;
      $display("FAIL rstmid_state: busy=%b a=%h b=%h want 0 0 0", busy, alu_a, alu_b); end
    total++; if (rsp0_valid !== 1'b0 || rsp0_result !== 32'd0 || req0_ready !== 1'b0)
      begin bad++;
      $display("FAIL rstmid_rsp: v=%b res=%h rdy=%b want 0 0 0", rsp0_valid, rsp0_result,
               req0_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin bad++;
        $display("FAIL rstmid_norsp[%0d]: v=%b busy=%b want 0 0", i, rsp0_valid, busy); end
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++;
      $display("FAIL rstmid_grant: got %b%b want 10", req0_ready, req1_ready); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_round_robin();
    test_overflow();
    test_logic();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, wanted completion");
    $fatal(1, "watchdog");
  end

endmodule
